// File: rtl/modn_slice_arbiter.sv
// -----------------------------------------------------------------------------
// modn_slice_arbiter
// Time-slice round-robin arbiter. One requester holds the shared resource for
// at most N counted cycles (one quantum). The grant rotates when the quantum
// expires or when the holder drops its request. Handover is back-to-back.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   req          level-sensitive request vector, bit i = requester i
//   slice_en     slice counter enable; low freezes the running quantum
//   grant        registered one-hot grant, zero when idle
//   grant_valid  registered, high while any grant bit is set
//   grant_id     registered binary index of the holder, zero when idle
//   slice_count  registered slice counter value
//   slice_tc     combinational terminal count of the quantum
// -----------------------------------------------------------------------------
module modn_slice_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned N     = 5,
    parameter int unsigned WIDTH = (N > 1) ? $clog2(N) : 1,
    parameter int unsigned IDW   = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic             slice_en,
    output logic [NREQ-1:0]  grant,
    output logic             grant_valid,
    output logic [IDW-1:0]   grant_id,
    output logic [WIDTH-1:0] slice_count,
    output logic             slice_tc
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(N - 1);
    localparam logic [IDW-1:0]   PTR_RST  = IDW'(NREQ - 1);

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic              valid_q, valid_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [WIDTH-1:0]  count_q, count_d;
    logic [IDW-1:0]    ptr_q, ptr_d;

    logic              tc_c;
    logic              release_c;
    logic [IDW-1:0]    base_c;
    logic              found_c;
    logic [IDW-1:0]    pick_c;

    // First set bit of r searching base+1, base+2, ... modulo NREQ; base itself last.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] r,
                                             input logic [IDW-1:0]  base);
        logic           found;
        logic [IDW-1:0] idx;
        int unsigned    cand;
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = 32'(base) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!found && r[IDW'(cand)]) begin
                found = 1'b1;
                idx   = IDW'(cand);
            end
        end
        return {found, idx};
    endfunction

    // Quantum terminal count, only meaningful while a grant is held
    assign tc_c = valid_q & slice_en & (count_q == CNT_LAST);

    // Release decision and round-robin candidate shared by both comb processes
    always_comb begin
        release_c = 1'b0;
        base_c    = ptr_q;
        if (state_q == GRANT) begin
            release_c = ~req[id_q] | tc_c;
            base_c    = id_q;
        end
        {found_c, pick_c} = rr_pick(req, base_c);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (found_c) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (release_c && !found_c) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        grant_d = grant_q;
        valid_d = valid_q;
        id_d    = id_q;
        count_d = count_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (found_c) begin
                    grant_d = NREQ'(1) << pick_c;
                    valid_d = 1'b1;
                    id_d    = pick_c;
                    count_d = '0;
                end
            end
            GRANT: begin
                if (release_c) begin
                    // Holder becomes the new priority reference whether or not anyone follows
                    ptr_d   = id_q;
                    count_d = '0;
                    if (found_c) begin
                        grant_d = NREQ'(1) << pick_c;
                        valid_d = 1'b1;
                        id_d    = pick_c;
                    end else begin
                        grant_d = '0;
                        valid_d = 1'b0;
                        id_d    = '0;
                    end
                end else if (slice_en) begin
                    count_d = (count_q == CNT_LAST) ? '0 : count_q + WIDTH'(1);
                end
            end
            default: begin
                grant_d = '0;
                valid_d = 1'b0;
                id_d    = '0;
                count_d = '0;
            end
        endcase
    end

    // Registered outputs and round-robin pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            count_q <= '0;
            ptr_q   <= PTR_RST;
        end else begin
            grant_q <= grant_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            count_q <= count_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign grant_id    = id_q;
    assign slice_count = count_q;
    assign slice_tc    = tc_c;

endmodule
